lab5_iram_loader: RTL and testbench
===================================

# lab5_iram_loader

Writer-side companion to the lab 5 instruction memory: receives a framed program image over a byte stream and writes it word-by-word into the 128 x 16 instruction RAM. During a load it holds the CPU in reset. It validates the frame header, word count and XOR checksum, then releases the CPU on success or latches an error.

## Interface
- TIMEOUT_CYCLES, 1000000: idle cycles allowed between accepted bytes during a load before the load aborts with an error.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle request to begin a load; honored only in IDLE, DONE or ERR.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA is valid.
- RX_READY  out  1  loader can accept a byte; a byte transfers on a cycle with RX_VALID && RX_READY.
- WE  out  1  single-cycle instruction RAM write strobe.
- WADDR  out  7  word address for the write (0..127).
- WDATA  out  16  instruction word for the write.
- CPU_HOLD  out  1  holds the CPU in reset while high.
- DONE  out  1  last load completed with a good checksum; sticky.
- ERR  out  1  last load failed; sticky.

## Operation
- Frame format, in order:
  - header byte 0xA5;
  - count byte N, valid range 1..128;
  - 2N data bytes, each word high byte first;
  - checksum byte equal to the XOR of all 2N data bytes.
- States: IDLE, HDR, CNT, HI, LO, WRITE, CSUM, DONE, ERR.
- Reset:
  - state is IDLE;
  - RX_READY, WE, DONE, ERR and CPU_HOLD are 0;
  - WADDR and WDATA are 0;
  - the word index, checksum accumulator and timeout counter are cleared.
- IDLE/DONE/ERR with START=1:
  - go to HDR; CPU_HOLD=1; DONE=0; ERR=0;
  - clear the word index and checksum.
- START in any other state is ignored.
- HDR: on an accepted byte, 0xA5 moves to CNT. Any other byte is discarded and the state stays HDR.
- CNT: on an accepted byte, 1..128 stores N and moves to HI. A value of 0 or >128 moves to ERR.
- HI: the accepted byte is stored as the high byte and XORed into the checksum; go to LO.
- LO: the accepted byte is XORed into the checksum. Register WDATA = {hi, byte} and WADDR = index; go to WRITE.
- WRITE (one cycle):
  - WE=1 and RX_READY=0;
  - increment the index;
  - if the new index equals N go to CSUM, otherwise go to HI.
- CSUM: on an accepted byte, a match with the accumulator goes to DONE, otherwise to ERR.
- DONE: DONE=1, CPU_HOLD=0.
- ERR: ERR=1; CPU_HOLD stays 1 so the CPU never runs a partial image.
- Words beyond N are not written; RAM contents above N-1 are left untouched.
- Timeout:
  - applies in HDR, CNT, HI, LO and CSUM;
  - the counter clears on every accepted byte and on entry from START;
  - reaching TIMEOUT_CYCLES-1 without an accepted byte goes to ERR.
- RESET_N low mid-load:
  - outputs return to reset values immediately, including CPU_HOLD=0;
  - a partially written RAM is not restored.

## Timing
- RX_READY is a registered output, high exactly in HDR, CNT, HI, LO and CSUM.
- WE is asserted the cycle after the accepted low byte and lasts exactly one cycle. WADDR and WDATA are stable during that cycle and hold their values afterward.
- Minimum load time for N words: 3N+3 cycles (header, count, 2N bytes, N write cycles, checksum). DONE is asserted the cycle after the checksum byte is accepted.
- CPU_HOLD rises the cycle after START and falls the cycle after a good checksum is accepted.
- DONE and ERR are never high simultaneously.

## Test plan
- Good load: START, then A5 02 12 34 AB CD with checksum 12^34^AB^CD = 0x40.
  - Two WE pulses: (WADDR=0, WDATA=0x1234) and (WADDR=1, WDATA=0xABCD).
  - DONE=1, CPU_HOLD=0.
- Bad checksum: the same frame with checksum 0x41 -> two writes occur, ERR=1, DONE=0, CPU_HOLD stays 1.
- Header resync and bad count: bytes 00 FF A5 00.
  - Leading junk is ignored; count 0 -> ERR.
  - A repeat with count 0x81 -> ERR, with no WE pulse.
- Full image with backpressure: N=128 (count byte 0x80) with RX_VALID toggling randomly.
  - 128 writes to addresses 0..127 in order.
  - RX_READY is never high in WRITE; DONE at end.
- Timeout with TIMEOUT_CYCLES=16: stall after the high byte of word 0.
  - ERR after 16 idle cycles, no WE.
  - A new START restarts cleanly and DONE follows a good frame.
- Reset mid-load: RESET_N low after word 1 is written.
  - All outputs return to reset values asynchronously.
  - START ignored while RESET_N is low; a normal load succeeds after release.

Source files
------------

// File: rtl/lab5_iram_loader.sv
// lab5_iram_loader
//   Writer-side loader for the lab 5 instruction RAM (128 x 16).
//
//   The loader receives a framed program image over a byte stream:
//     0xA5, N (1..128), 2N data bytes (each word high byte first), XOR checksum.
//   It writes the image word by word into the RAM. The CPU is held in reset for
//   the whole load. On a good checksum the CPU is released and DONE is set.
//   Any frame error or stall leaves the CPU held and sets ERR.
//
// Ports
//   CLK       in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   START     in   one-cycle load request, honoured in IDLE/DONE/ERR only
//   RX_DATA   in   [7:0] incoming byte
//   RX_VALID  in   RX_DATA valid
//   RX_READY  out  loader accepts a byte (transfer = RX_VALID && RX_READY)
//   WE        out  one-cycle instruction RAM write strobe
//   WADDR     out  [6:0] write word address
//   WDATA     out  [15:0] write data
//   CPU_HOLD  out  keeps the CPU in reset while high
//   DONE      out  last load good (sticky until next START)
//   ERR       out  last load failed (sticky until next START)
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | out of reset, nothing loaded yet
// HDR     | hunting for the 0xA5 header, other bytes discarded
// CNT     | waiting for the word count N
// HI      | waiting for the high byte of the current word
// LO      | waiting for the low byte of the current word
// WRITE   | one-cycle RAM write of the assembled word
// CSUM    | waiting for the checksum byte
// DONE    | image good, CPU released
// ERR     | load failed, CPU kept in reset

module lab5_iram_loader #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        RX_READY,
  output logic        WE,
  output logic [6:0]  WADDR,
  output logic [15:0] WDATA,
  output logic        CPU_HOLD,
  output logic        DONE,
  output logic        ERR
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] MAX_WORDS = 8'd128;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_CNT,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t state, state_nxt;

  logic          accept;
  logic          timed;
  logic          tmo_hit;
  logic          start_ok;
  logic          last_word;
  logic [7:0]    idx;
  logic [7:0]    word_cnt;
  logic [7:0]    hi_byte;
  logic [7:0]    csum;
  logic [TW-1:0] tmr;

  logic rx_ready_nxt;
  logic we_nxt;
  logic hold_nxt;
  logic done_nxt;
  logic err_nxt;

  assign accept    = RX_VALID && RX_READY;
  assign timed     = state inside {ST_HDR, ST_CNT, ST_HI, ST_LO, ST_CSUM};
  // Timer is a down-counter reloaded on every accepted byte; reaching zero
  // with no byte arriving means TIMEOUT_CYCLES idle cycles have elapsed.
  assign tmo_hit   = timed && !accept && (tmr == '0);
  assign start_ok  = START && (state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign last_word = (idx + 8'd1) == word_cnt;

  // state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    if (tmo_hit) begin
      state_nxt = ST_ERR;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (START) state_nxt = ST_HDR;
        end
        ST_HDR: begin
          if (accept && (RX_DATA == HDR_BYTE)) state_nxt = ST_CNT;
        end
        ST_CNT: begin
          if (accept) begin
            state_nxt = ((RX_DATA != 8'd0) && (RX_DATA <= MAX_WORDS)) ? ST_HI : ST_ERR;
          end
        end
        ST_HI: begin
          if (accept) state_nxt = ST_LO;
        end
        ST_LO: begin
          if (accept) state_nxt = ST_WRITE;
        end
        ST_WRITE: begin
          state_nxt = last_word ? ST_CSUM : ST_HI;
        end
        ST_CSUM: begin
          if (accept) state_nxt = (RX_DATA == csum) ? ST_DONE : ST_ERR;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so each one is
  // glitch-free and lines up exactly with the state it describes.
  always_comb begin
    rx_ready_nxt = 1'b0;
    we_nxt       = 1'b0;
    hold_nxt     = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    case (state_nxt)
      ST_HDR, ST_CNT, ST_HI, ST_LO, ST_CSUM: begin
        rx_ready_nxt = 1'b1;
        hold_nxt     = 1'b1;
      end
      ST_WRITE: begin
        we_nxt   = 1'b1;
        hold_nxt = 1'b1;
      end
      ST_DONE: begin
        done_nxt = 1'b1;
      end
      ST_ERR: begin
        err_nxt  = 1'b1;
        hold_nxt = 1'b1;
      end
      default: begin
        hold_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RX_READY <= 1'b0;
      WE       <= 1'b0;
      CPU_HOLD <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      RX_READY <= rx_ready_nxt;
      WE       <= we_nxt;
      CPU_HOLD <= hold_nxt;
      DONE     <= done_nxt;
      ERR      <= err_nxt;
    end
  end

  // datapath: word index, count, checksum, timer, write address/data
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idx      <= 8'd0;
      word_cnt <= 8'd0;
      hi_byte  <= 8'd0;
      csum     <= 8'd0;
      tmr      <= '0;
      WADDR    <= 7'd0;
      WDATA    <= 16'd0;
    end else begin
      if (start_ok) begin
        idx  <= 8'd0;
        csum <= 8'd0;
        tmr  <= TMO_LOAD;
      end else if (timed) begin
        if (accept) begin
          tmr <= TMO_LOAD;
        end else if (tmr != '0) begin
          tmr <= tmr - TW'(1);
        end
      end

      if (accept) begin
        case (state)
          ST_CNT: begin
            word_cnt <= RX_DATA;
          end
          ST_HI: begin
            hi_byte <= RX_DATA;
            csum    <= csum ^ RX_DATA;
          end
          ST_LO: begin
            csum  <= csum ^ RX_DATA;
            WDATA <= {hi_byte, RX_DATA};
            WADDR <= idx[6:0];
          end
          default: begin
          end
        endcase
      end

      if (state == ST_WRITE) begin
        idx <= idx + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lab5_iram_loader.sv
module tb_lab5_iram_loader;

  localparam int TMO = 16;

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic        WE;
  logic [6:0]  WADDR;
  logic [15:0] WDATA;
  logic        CPU_HOLD;
  logic        DONE;
  logic        ERR;

  lab5_iram_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .START(START),
    .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID),
    .RX_READY(RX_READY),
    .WE(WE),
    .WADDR(WADDR),
    .WDATA(WDATA),
    .CPU_HOLD(CPU_HOLD),
    .DONE(DONE),
    .ERR(ERR)
  );

  typedef struct packed {
    logic [63:0] bytes;   // left-aligned byte stream
    logic [3:0]  nbytes;  // bytes the loader will accept
    logic [7:0]  nwr;     // expected write count
    logic [15:0] w0;
    logic [15:0] w1;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[6];

  int          n_cmp;
  int          n_fail;
  int          overlap;
  longint      t0;
  bit          ok;
  logic [22:0] got_q[$];
  logic [22:0] exp_q[$];
  logic [7:0]  fr_q[$];
  int          m_outcome;   // 0 incomplete, 1 good, 2 error
  int          m_consumed;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // write monitor: every WE cycle is one RAM write
  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      got_q.push_back({WADDR, WDATA});
      check("rdy_in_write", 32'(RX_READY), 32'd0);
    end
    if (DONE && ERR) overlap++;
  end

  task automatic start_load();
    START = 1'b1;
    @(posedge CLK);
    t0 = $time;
    #1;
    START = 1'b0;
    check("start_hold", 32'(CPU_HOLD), 32'd1);
    check("start_ready", 32'(RX_READY), 32'd1);
    check("start_clr", {30'd0, DONE, ERR}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit acc);
    acc = 1'b0;
    RX_VALID = 1'b0;
    repeat (gap) begin
      RX_DATA = 8'($urandom);
      @(posedge CLK);
      #1;
    end
    RX_DATA  = b;
    RX_VALID = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge CLK);
      if (RX_READY) begin
        @(posedge CLK);
        #1;
        acc = 1'b1;
      end
    end
    RX_VALID = 1'b0;
  endtask

  // Reference: parse the byte list as a frame and list the writes it implies.
  task automatic model();
    int i;
    int n;
    logic [7:0] x;
    i = 0;
    x = 8'd0;
    exp_q.delete();
    m_outcome  = 0;
    m_consumed = fr_q.size();
    while (i < fr_q.size() && fr_q[i] != 8'hA5) i++;
    if (i + 1 >= fr_q.size()) return;
    i++;
    n = int'(fr_q[i]);
    i++;
    if (n == 0 || n > 128) begin
      m_outcome  = 2;
      m_consumed = i;
      return;
    end
    for (int w = 0; w < n; w++) begin
      exp_q.push_back({7'(w), fr_q[i], fr_q[i+1]});
      x ^= fr_q[i] ^ fr_q[i+1];
      i += 2;
    end
    m_outcome  = (fr_q[i] == x) ? 1 : 2;
    m_consumed = i + 1;
  endtask

  task automatic compare_writes();
    check("we_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("write_%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
    got_q.delete();
  endtask

  task automatic check_outcome(input int outc);
    check("done", 32'(DONE), 32'(outc == 1));
    check("err", 32'(ERR), 32'(outc == 2));
    check("cpu_hold", 32'(CPU_HOLD), 32'(outc != 1));
    check("ready_end", 32'(RX_READY), 32'd0);
  endtask

  task automatic load_vec(input int v);
    fr_q.delete();
    for (int k = 0; k < int'(vecs[v].nbytes); k++)
      fr_q.push_back(vecs[v].bytes[63-8*k -: 8]);
  endtask

  task automatic run_frame(input int gap_max);
    bit acc;
    model();
    got_q.delete();
    start_load();
    for (int k = 0; k < m_consumed; k++) begin
      send_byte(fr_q[k], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)), acc);
      check("byte_accept", 32'(acc), 32'd1);
    end
    check_outcome(m_outcome);
    if (gap_max == 0)
      check("load_cycles", 32'(($time - 1 - t0) / 10), 32'(m_consumed + exp_q.size()));
    @(negedge CLK);
    #1;
    compare_writes();
  endtask

  task automatic build_random(input int n, input bit corrupt, input bit bad_count, input int junk);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'd0;
    fr_q.delete();
    repeat (junk) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      fr_q.push_back(b);
    end
    fr_q.push_back(8'hA5);
    if (bad_count)
      fr_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(129, 255)));
    else
      fr_q.push_back(8'(n));
    for (int k = 0; k < 2 * n; k++) begin
      b = 8'($urandom);
      x ^= b;
      fr_q.push_back(b);
    end
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    fr_q.push_back(x);
  endtask

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    overlap  = 0;
    t0       = 0;
    RESET_N  = 1'b0;
    START    = 1'b0;
    RX_VALID = 1'b0;
    RX_DATA  = 8'd0;

    vecs[0] = '{64'hA5021234_ABCD4000, 4'd7, 8'd2, 16'h1234, 16'hABCD, 1'b1, 1'b0};
    vecs[1] = '{64'hA5021234_ABCD4100, 4'd7, 8'd2, 16'h1234, 16'hABCD, 1'b0, 1'b1};
    vecs[2] = '{64'h00FFA500_00000000, 4'd4, 8'd0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{64'hA5810000_00000000, 4'd2, 8'd0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[4] = '{64'hA501DEAD_73000000, 4'd5, 8'd1, 16'hDEAD, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{64'h5AA50100_01010000, 4'd6, 8'd1, 16'h0001, 16'h0000, 1'b1, 1'b0};

    // reset state
    #2;
    check("rst_ready", 32'(RX_READY), 32'd0);
    check("rst_we", 32'(WE), 32'd0);
    check("rst_hold", 32'(CPU_HOLD), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_waddr", 32'(WADDR), 32'd0);
    check("rst_wdata", 32'(WDATA), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    check("idle_ready", 32'(RX_READY), 32'd0);
    check("idle_hold", 32'(CPU_HOLD), 32'd0);

    // directed table, no backpressure
    for (int v = 0; v < 6; v++) begin
      load_vec(v);
      got_q.delete();
      start_load();
      for (int k = 0; k < int'(vecs[v].nbytes); k++) begin
        send_byte(fr_q[k], 0, ok);
        check("tbl_accept", 32'(ok), 32'd1);
      end
      check($sformatf("tbl%0d_done", v), 32'(DONE), 32'(vecs[v].done));
      check($sformatf("tbl%0d_err", v), 32'(ERR), 32'(vecs[v].err));
      check($sformatf("tbl%0d_hold", v), 32'(CPU_HOLD), 32'(!vecs[v].done));
      check($sformatf("tbl%0d_cycles", v), 32'(($time - 1 - t0) / 10),
            32'(vecs[v].nbytes) + 32'(vecs[v].nwr));
      @(negedge CLK);
      #1;
      exp_q.delete();
      if (vecs[v].nwr > 8'd0) exp_q.push_back({7'd0, vecs[v].w0});
      if (vecs[v].nwr > 8'd1) exp_q.push_back({7'd1, vecs[v].w1});
      compare_writes();
    end

    // timeout: stall after the high byte of word 0
    got_q.delete();
    start_load();
    send_byte(8'hA5, 0, ok);
    send_byte(8'h01, 0, ok);
    send_byte(8'h12, 0, ok);
    check("tmo_accept", 32'(ok), 32'd1);
    repeat (TMO - 1) @(posedge CLK);
    #1;
    check("tmo_not_yet", 32'(ERR), 32'd0);
    @(posedge CLK);
    #1;
    check("tmo_err", 32'(ERR), 32'd1);
    check("tmo_hold", 32'(CPU_HOLD), 32'd1);
    check("tmo_ready", 32'(RX_READY), 32'd0);
    exp_q.delete();
    compare_writes();
    load_vec(0);
    run_frame(0);

    // reset mid-load, after both words have been written
    load_vec(0);
    model();
    got_q.delete();
    start_load();
    for (int k = 0; k < 6; k++) send_byte(fr_q[k], 0, ok);
    @(negedge CLK);
    #2;
    RESET_N = 1'b0;
    #1;
    check("mid_rst_ready", 32'(RX_READY), 32'd0);
    check("mid_rst_we", 32'(WE), 32'd0);
    check("mid_rst_hold", 32'(CPU_HOLD), 32'd0);
    check("mid_rst_flags", {30'd0, DONE, ERR}, 32'd0);
    check("mid_rst_waddr", 32'(WADDR), 32'd0);
    check("mid_rst_wdata", 32'(WDATA), 32'd0);
    START = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_start_hold", 32'(CPU_HOLD), 32'd0);
    check("rst_start_ready", 32'(RX_READY), 32'd0);
    START   = 1'b0;
    RESET_N = 1'b1;
    compare_writes();
    load_vec(4);
    run_frame(0);

    // randomized frames with backpressure; first one is the full image
    build_random(128, 1'b0, 1'b0, 0);
    run_frame(3);
    for (int r = 0; r < 6; r++) begin
      build_random(int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 4) == 0), int'($urandom_range(0, 2)));
      run_frame(3);
    end

    check("done_err_overlap", 32'(overlap), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
